// File: rtl/ahb_arbiter_n.sv
// N-master AHB arbiter: registered one-hot grant, owner index and hmastlock,
// with ownership held across fixed bursts and locked sequences. Define
// AHB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority.
module ahb_arbiter_n #(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_W       = $clog2(NUM_MASTERS),
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic                   hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MASTER_W-1:0]    hmaster,
  output logic                   hmastlock
);

  localparam int unsigned NM = NUM_MASTERS;
  localparam logic [NUM_MASTERS-1:0] GRANT_LSB = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = GRANT_LSB << DEFAULT_MASTER;
  localparam logic [MASTER_W-1:0]    DEF_IDX   = MASTER_W'(DEFAULT_MASTER);

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {ARB, BURST, LOCK} state_e;

  state_e                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [MASTER_W-1:0]      master_q, master_d;
  logic                     mlock_q, mlock_d;
  logic [3:0]               cnt_q, cnt_d;

  logic [MASTER_W-1:0]      winner;
  logic                     found;
  logic [3:0]               burst_len;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  int unsigned idx;

  // Search starts just past the current owner, so hmaster doubles as the pointer.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NM; i++) begin
      idx = (32'(master_q) + i) % NM;
      if (!found && hbusreq[idx[MASTER_W-1:0]]) begin
        winner = idx[MASTER_W-1:0];
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (!found && hbusreq[i[MASTER_W-1:0]]) begin
        winner = i[MASTER_W-1:0];
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    burst_len = 4'd0;
    case (hburst)
      3'b010, 3'b011: burst_len = 4'd3;
      3'b100, 3'b101: burst_len = 4'd7;
      3'b110, 3'b111: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    mlock_d  = mlock_q;
    cnt_d    = cnt_q;
    if (hready) begin
      case (state_q)
        ARB: begin
          if (hlock[master_q]) begin
            state_d = LOCK;
            mlock_d = 1'b1;
          end else if (htrans == TR_NONSEQ && burst_len != 4'd0) begin
            state_d = BURST;
            cnt_d   = burst_len;
          end else begin
            grant_d  = GRANT_LSB << winner;
            master_d = winner;
            mlock_d  = hlock[winner];
          end
        end
        BURST: begin
          // cnt_q holds the SEQ beats still owed; the beat that exhausts it ends the burst.
          if (hresp) begin
            state_d = ARB;
            cnt_d   = '0;
          end else if (htrans == TR_SEQ) begin
            if (cnt_q <= 4'd1) begin
              state_d = ARB;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        LOCK: begin
          mlock_d = hlock[master_q];
          if (!hlock[master_q]) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ARB;
      grant_q  <= DEF_GRANT;
      master_q <= DEF_IDX;
      mlock_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      mlock_q  <= mlock_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = master_q;
  assign hmastlock = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter_n.sv
// Scoreboard bench for ahb_arbiter_n: a transaction-level ownership model
// predicts grant/owner/lock after every edge; monitors compare independently.
module tb_ahb_arbiter_n;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic       hclk    = 1'b0;
  logic       hresetn = 1'b0;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock   = '0;
  logic [1:0] htrans  = '0;
  logic [2:0] hburst  = '0;
  logic       hready  = 1'b1;
  logic       hresp   = 1'b0;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  always #5 hclk = ~hclk;

  ahb_arbiter_n #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       ml;
    int         sc;
    bit         async_chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   sc     = 0;

  // Ownership model: who owns the bus, and why it is being held.
  int owner;
  bit lock_out;
  bit holding_lock;
  bit holding_burst;
  int seq_beats_owed;

  function automatic int pick(logic [3:0] req, int prev);
`ifdef AHB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (prev + k) % N;
      if (req[c]) return c;
    end
`else
    for (int c = 0; c < N; c++) if (req[c]) return c;
`endif
    return DEF;
  endfunction

  function automatic void model_reset();
    owner          = DEF;
    lock_out       = 1'b0;
    holding_lock   = 1'b0;
    holding_burst  = 1'b0;
    seq_beats_owed = 0;
  endfunction

  function automatic void model_step();
    if (!hready) return;
    if (holding_lock) begin
      lock_out = hlock[owner];
      if (!hlock[owner]) holding_lock = 1'b0;
    end else if (holding_burst) begin
      if (hresp) holding_burst = 1'b0;
      else if (htrans == 2'b11) begin
        seq_beats_owed--;
        if (seq_beats_owed == 0) holding_burst = 1'b0;
      end
    end else if (hlock[owner]) begin
      holding_lock = 1'b1;
      lock_out     = 1'b1;
    end else if (htrans == 2'b10 && hburst >= 3'd2) begin
      holding_burst  = 1'b1;
      seq_beats_owed = (1 << (int'(hburst) / 2 + 1)) - 1;
    end else begin
      owner    = pick(hbusreq, owner);
      lock_out = hlock[owner];
    end
  endfunction

  function automatic void push_exp(bit async_chk);
    exp_t e;
    e.g         = 4'(1 << owner);
    e.m         = 2'(owner);
    e.ml        = lock_out;
    e.sc        = sc;
    e.async_chk = async_chk;
    sb.push_back(e);
  endfunction

  function automatic void check(exp_t e);
    checks += 3;
    if (hgrant !== e.g) begin
      errors++;
      $display("FAIL sc%0d hgrant got %b want %b at %0t", e.sc, hgrant, e.g, $time);
    end
    if (hmaster !== e.m) begin
      errors++;
      $display("FAIL sc%0d hmaster got %0d want %0d at %0t", e.sc, hmaster, e.m, $time);
    end
    if (hmastlock !== e.ml) begin
      errors++;
      $display("FAIL sc%0d hmastlock got %b want %b at %0t", e.sc, hmastlock, e.ml, $time);
    end
  endfunction

  initial forever begin
    @(posedge hclk);
    #1;
    if (sb.size() > 0 && !sb[0].async_chk) check(sb.pop_front());
  end

  initial forever begin
    @(negedge hresetn);
    #1;
    if (sb.size() > 0 && sb[0].async_chk) check(sb.pop_front());
  end

  task automatic drive(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic rsp);
    @(negedge hclk);
    hresetn = 1'b1;
    hbusreq = req;
    hlock   = lk;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rsp;
    model_step();
    push_exp(1'b0);
  endtask

  task automatic hold_reset(input int n);
    repeat (n) begin
      @(negedge hclk);
      hresetn = 1'b0;
      hbusreq = '0;
      hlock   = '0;
      htrans  = '0;
      hburst  = '0;
      hready  = 1'b1;
      hresp   = 1'b0;
      model_reset();
      push_exp(1'b0);
    end
  endtask

  // Reset lands mid-cycle, well away from either clock edge.
  task automatic async_reset();
    @(negedge hclk);
    model_reset();
    push_exp(1'b1);
    #2 hresetn = 1'b0;
  endtask

  initial begin
    logic [3:0] lk;
    lk = '0;
    model_reset();

    sc = 1;
    hold_reset(3);
    repeat (10) drive(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);

    sc = 2;
    repeat (6) drive(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 1'b0);

    sc = 3;
    drive(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b0110, 4'b0000, 2'b10, 3'b011, 1'b1, 1'b0);
    drive(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
    drive(4'b0110, 4'b0000, 2'b01, 3'b011, 1'b1, 1'b0);
    drive(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
    drive(4'b0110, 4'b0000, 2'b11, 3'b011, 1'b1, 1'b0);
    drive(4'b0110, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);

    sc = 4;
    drive(4'b1010, 4'b0000, 2'b10, 3'b101, 1'b1, 1'b0);
    repeat (3) drive(4'b1010, 4'b0000, 2'b11, 3'b101, 1'b1, 1'b0);
    repeat (3) drive(4'b1010, 4'b0000, 2'b11, 3'b101, 1'b0, 1'b0);
    repeat (4) drive(4'b1010, 4'b0000, 2'b11, 3'b101, 1'b1, 1'b0);
    repeat (2) drive(4'b1000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);

    sc = 5;
    drive(4'b1000, 4'b1000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b1111, 4'b1000, 2'b10, 3'b011, 1'b1, 1'b0);
    drive(4'b1111, 4'b1000, 2'b11, 3'b011, 1'b1, 1'b0);
    drive(4'b1111, 4'b1000, 2'b11, 3'b011, 1'b0, 1'b1);
    drive(4'b1111, 4'b1000, 2'b11, 3'b011, 1'b1, 1'b1);
    drive(4'b1111, 4'b1000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b1111, 4'b1000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);

    sc = 6;
    drive(4'b0001, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b0101, 4'b0000, 2'b10, 3'b111, 1'b1, 1'b0);
    drive(4'b0101, 4'b0000, 2'b11, 3'b111, 1'b1, 1'b0);
    drive(4'b0101, 4'b0000, 2'b11, 3'b111, 1'b0, 1'b1);
    drive(4'b0100, 4'b0000, 2'b11, 3'b111, 1'b1, 1'b1);
    drive(4'b0100, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    drive(4'b0100, 4'b0000, 2'b10, 3'b110, 1'b1, 1'b0);
    drive(4'b0100, 4'b0000, 2'b11, 3'b110, 1'b1, 1'b0);
    async_reset();
    hold_reset(2);

    sc = 7;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        hold_reset(1);
      end
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) lk[b] = ~lk[b];
      drive(4'($urandom), lk, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0);
    end

    repeat (3) @(posedge hclk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
